// File: rtl/ula_raster_if.sv
// Raster generator bundle: pixel enables and timing configuration in, raster counters,
// sync, interrupt and flash phase out. The generator side uses "master", consumers use "slave".
interface ula_raster_if;
   logic       ce_7mp;
   logic       ce_7mn;
   logic [1:0] mode;
   logic [8:0] cfg_htotal;
   logic [8:0] cfg_vtotal;
   logic [8:0] cfg_int_v;
   logic [8:0] cfg_int_h;
   logic       line_int_en;
   logic [8:0] line_int_line;
   logic       line_int_ack;

   logic [8:0] hc;
   logic [8:0] vc;
   logic       border;
   logic       hsync;
   logic       vsync;
   logic       nINT;
   logic       line_irq;
   logic       flash;
   logic       int_busy;

   // Strobes are qualifiers sampled on every clk_sys edge; there is no backpressure.
   modport master (
      input  ce_7mp, ce_7mn, mode, cfg_htotal, cfg_vtotal, cfg_int_v, cfg_int_h,
             line_int_en, line_int_line, line_int_ack,
      output hc, vc, border, hsync, vsync, nINT, line_irq, flash, int_busy
   );

   modport slave (
      output ce_7mp, ce_7mn, mode, cfg_htotal, cfg_vtotal, cfg_int_v, cfg_int_h,
             line_int_en, line_int_line, line_int_ack,
      input  hc, vc, border, hsync, vsync, nINT, line_irq, flash, int_busy
   );
endinterface

// File: rtl/ula_raster_gen.sv
// ULA raster timing generator: counters, sync, frame INT pulse, flash phase, line interrupt.
// Define ULA_RASTER_LINE_INT_EN to compile in the sticky line interrupt; otherwise line_irq is 0.
module ula_raster_gen #(
   parameter int INT_LEN = 32,
   parameter int FLASH_W = 5
) (
   input logic       clk_sys,
   input logic       reset,
   ula_raster_if.master rif
);

   typedef enum logic {INT_IDLE, INT_LOW} int_state_t;

   localparam logic [7:0] INT_CNT_INIT = 8'(INT_LEN - 1);

   logic [8:0]         hc_q, hc_d, vc_q, vc_d;
   logic [FLASH_W-1:0] flash_q, flash_d;
   logic [1:0]         act_mode_q, act_mode_d;
   logic [8:0]         act_ht_q, act_ht_d, act_vt_q, act_vt_d;
   logic [8:0]         act_iv_q, act_iv_d, act_ih_q, act_ih_d;
   logic               hsync_q, hsync_d, vsync_q, vsync_d;
   logic               line_irq_q, line_irq_d;

   logic [8:0] h_tot, v_tot, int_v, int_h, hs_lo, hs_hi, vs_lo, vs_hi;
   logic       end_of_line, end_of_frame, int_hit;

   int_state_t int_state_q;
   logic [7:0] int_cnt_q;
   logic       nint_q;

   // Per-mode timing, decoded from the mode latched at the last frame boundary.
   always_comb begin
      h_tot = 9'd447; v_tot = 9'd319; int_v = 9'd239; int_h = 9'd326;
      hs_lo = 9'd338; hs_hi = 9'd369; vs_lo = 9'd248; vs_hi = 9'd255;
      case (act_mode_q)
         2'd1: begin
            h_tot = 9'd447; v_tot = 9'd311; int_v = 9'd248; int_h = 9'd4;
            hs_lo = 9'd336; hs_hi = 9'd367; vs_lo = 9'd240; vs_hi = 9'd243;
         end
         2'd2: begin
            h_tot = 9'd455; v_tot = 9'd310; int_v = 9'd248; int_h = 9'd8;
            hs_lo = 9'd340; hs_hi = 9'd371; vs_lo = 9'd240; vs_hi = 9'd243;
         end
         2'd3: begin
            h_tot = act_ht_q; v_tot = act_vt_q; int_v = act_iv_q; int_h = act_ih_q;
         end
         default: ;
      endcase
   end

   assign end_of_line  = (hc_q == h_tot);
   assign end_of_frame = end_of_line && (vc_q == v_tot);
   assign int_hit      = (vc_q == int_v) && (hc_q == int_h);

   always_comb begin
      hc_d = hc_q; vc_d = vc_q; flash_d = flash_q;
      act_mode_d = act_mode_q; act_ht_d = act_ht_q; act_vt_d = act_vt_q;
      act_iv_d = act_iv_q; act_ih_d = act_ih_q;
      hsync_d = hsync_q; vsync_d = vsync_q;
      if (rif.ce_7mp) begin
         if (end_of_line) begin
            hc_d = 9'd0;
            if (end_of_frame) begin
               // New timing only ever takes effect from (0,0).
               vc_d       = 9'd0;
               flash_d    = flash_q + FLASH_W'(1);
               act_mode_d = rif.mode;
               act_ht_d   = rif.cfg_htotal;
               act_vt_d   = rif.cfg_vtotal;
               act_iv_d   = rif.cfg_int_v;
               act_ih_d   = rif.cfg_int_h;
            end else begin
               vc_d = vc_q + 9'd1;
            end
         end else begin
            hc_d = hc_q + 9'd1;
         end
      end
      if (rif.ce_7mn) begin
         hsync_d = (hc_q >= hs_lo) && (hc_q <= hs_hi);
         vsync_d = (vc_q >= vs_lo) && (vc_q <= vs_hi);
      end
   end

`ifdef ULA_RASTER_LINE_INT_EN
   // Set has priority over a coincident acknowledge.
   always_comb begin
      line_irq_d = line_irq_q;
      if (rif.line_int_ack) line_irq_d = 1'b0;
      if (rif.ce_7mp && end_of_line && rif.line_int_en && (vc_d == rif.line_int_line))
         line_irq_d = 1'b1;
   end
`else
   logic unused_line_int;
   assign unused_line_int = ^{rif.line_int_en, rif.line_int_line, rif.line_int_ack};
   always_comb line_irq_d = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hc_q       <= 9'd0;
         vc_q       <= 9'd0;
         flash_q    <= '0;
         act_mode_q <= rif.mode;
         act_ht_q   <= rif.cfg_htotal;
         act_vt_q   <= rif.cfg_vtotal;
         act_iv_q   <= rif.cfg_int_v;
         act_ih_q   <= rif.cfg_int_h;
         hsync_q    <= 1'b0;
         vsync_q    <= 1'b0;
         line_irq_q <= 1'b0;
      end else begin
         hc_q       <= hc_d;
         vc_q       <= vc_d;
         flash_q    <= flash_d;
         act_mode_q <= act_mode_d;
         act_ht_q   <= act_ht_d;
         act_vt_q   <= act_vt_d;
         act_iv_q   <= act_iv_d;
         act_ih_q   <= act_ih_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         line_irq_q <= line_irq_d;
      end
   end

   // Frame INT pulse: a trigger seen while low is ignored, so the pulse never restarts.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         int_state_q <= INT_IDLE;
         int_cnt_q   <= 8'd0;
         nint_q      <= 1'b1;
      end else if (rif.ce_7mn) begin
         case (int_state_q)
            INT_IDLE: begin
               if (int_hit) begin
                  int_state_q <= INT_LOW;
                  int_cnt_q   <= INT_CNT_INIT;
                  nint_q      <= 1'b0;
               end
            end
            INT_LOW: begin
               if (int_cnt_q == 8'd0) begin
                  int_state_q <= INT_IDLE;
                  nint_q      <= 1'b1;
               end else begin
                  int_cnt_q <= int_cnt_q - 8'd1;
               end
            end
            default: int_state_q <= INT_IDLE;
         endcase
      end
   end

   assign rif.hc       = hc_q;
   assign rif.vc       = vc_q;
   assign rif.border   = (vc_q >= 9'd192) | (hc_q >= 9'd256);
   assign rif.hsync    = hsync_q;
   assign rif.vsync    = vsync_q;
   assign rif.nINT     = nint_q;
   assign rif.line_irq = line_irq_q;
   assign rif.flash    = flash_q[FLASH_W-1];
   assign rif.int_busy = (int_state_q == INT_LOW);

endmodule

// File: tb/tb_ula_raster_gen.sv
// Randomised bench for ula_raster_gen: a linear-position frame model predicts every output
// after each clock; a negedge monitor pops the expected queue and compares.
module tb_ula_raster_gen;
  localparam int INT_LEN = 32;
  localparam int TB_FLASH_W = 1;
  localparam int W = 25;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  ula_raster_if rif ();

  ula_raster_gen #(.INT_LEN(INT_LEN), .FLASH_W(TB_FLASH_W)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .rif     (rif)
  );

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: position is a linear tick index within the frame.
  int m_H = 447, m_V = 311, m_iv = 248, m_ih = 4, m_hs = 336, m_vs_lo = 240, m_vs_hi = 243;
  int m_pos = 0, m_flash = 0, m_left = 0;
  bit m_nint = 1, m_hsync = 0, m_vsync = 0, m_irq = 0;

  task automatic load_active();
    case (rif.mode)
      2'd1: begin m_H = 447; m_V = 311; m_iv = 248; m_ih = 4;   m_hs = 336; m_vs_lo = 240; m_vs_hi = 243; end
      2'd2: begin m_H = 455; m_V = 310; m_iv = 248; m_ih = 8;   m_hs = 340; m_vs_lo = 240; m_vs_hi = 243; end
      2'd0: begin m_H = 447; m_V = 319; m_iv = 239; m_ih = 326; m_hs = 338; m_vs_lo = 248; m_vs_hi = 255; end
      default: begin
        m_H = int'(rif.cfg_htotal); m_V = int'(rif.cfg_vtotal);
        m_iv = int'(rif.cfg_int_v); m_ih = int'(rif.cfg_int_h);
        m_hs = 338; m_vs_lo = 248; m_vs_hi = 255;
      end
    endcase
  endtask

  function automatic logic [W-1:0] model_out();
    int hc, vc;
    bit brd, fl;
    hc = m_pos % (m_H + 1);
    vc = m_pos / (m_H + 1);
    brd = (vc >= 192) || (hc >= 256);
    fl = ((m_flash % (1 << TB_FLASH_W)) >> (TB_FLASH_W - 1)) != 0;
    return {9'(hc), 9'(vc), brd, m_hsync, m_vsync, m_nint, m_irq, fl, ~m_nint};
  endfunction

  task automatic step();
    int hc, vc;
    bit set;
    if (reset) begin
      m_pos = 0; m_flash = 0; m_left = 0;
      m_nint = 1; m_hsync = 0; m_vsync = 0; m_irq = 0;
      load_active();
    end else begin
      hc = m_pos % (m_H + 1);
      vc = m_pos / (m_H + 1);
      if (rif.ce_7mn) begin
        m_hsync = (hc >= m_hs) && (hc <= m_hs + 31);
        m_vsync = (vc >= m_vs_lo) && (vc <= m_vs_hi);
        if (!m_nint) begin
          m_left--;
          if (m_left == 0) m_nint = 1;
        end else if (vc == m_iv && hc == m_ih) begin
          m_nint = 0;
          m_left = INT_LEN;
        end
      end
      set = 0;
      if (rif.ce_7mp) begin
        m_pos++;
        if (m_pos == (m_H + 1) * (m_V + 1)) begin
          m_pos = 0;
          m_flash++;
          load_active();
        end
        set = (m_pos % (m_H + 1) == 0) && rif.line_int_en &&
              (m_pos / (m_H + 1) == int'(rif.line_int_line));
      end
`ifdef ULA_RASTER_LINE_INT_EN
      if (set) m_irq = 1;
      else if (rif.line_int_ack) m_irq = 0;
`else
      m_irq = set & 1'b0;
`endif
    end
    @(posedge clk_sys);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic run(input int n, input int p_ce);
    for (int i = 0; i < n; i++) begin
      rif.ce_7mp = ($urandom_range(0, 99) < p_ce);
      rif.ce_7mn = 1'($urandom_range(0, 1));
      rif.line_int_ack = ($urandom_range(0, 999) == 0);
      step();
    end
  endtask

  task automatic do_reset(input logic [1:0] md);
    rif.mode = md;
    reset = 1'b1;
    rif.ce_7mp = 1'b1;
    rif.ce_7mn = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare against the oldest prediction.
  always @(negedge clk_sys) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {rif.hc, rif.vc, rif.border, rif.hsync, rif.vsync, rif.nINT,
           rif.line_irq, rif.flash, rif.int_busy};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL raster t=%0t got hc=%0d vc=%0d brd=%b hs=%b vs=%b nint=%b irq=%b fl=%b busy=%b want hc=%0d vc=%0d brd=%b hs=%b vs=%b nint=%b irq=%b fl=%b busy=%b",
                 $time, a[24:16], a[15:7], a[6], a[5], a[4], a[3], a[2], a[1], a[0],
                 e[24:16], e[15:7], e[6], e[5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit did_rst;
    int vcm;
    reset = 1'b1;
    rif.ce_7mp = 1'b0; rif.ce_7mn = 1'b0;
    rif.mode = 2'd1;
    rif.cfg_htotal = 9'd299; rif.cfg_vtotal = 9'd259;
    rif.cfg_int_v = 9'd10; rif.cfg_int_h = 9'd20;
    rif.line_int_en = 1'b0; rif.line_int_line = 9'd0; rif.line_int_ack = 1'b0;

    // 48K, 128K and Pentagon line timing, hsync windows and border.
    do_reset(2'd1);
    run(1200, 90);
    do_reset(2'd2);
    run(1200, 90);
    do_reset(2'd0);
    run(1000, 90);

    // Custom timing: INT at (10,20), reset five ticks into the pulse, then an unreachable INT line.
    rif.cfg_htotal = 9'd299; rif.cfg_vtotal = 9'd259;
    rif.cfg_int_v = 9'd10; rif.cfg_int_h = 9'd20;
    do_reset(2'd3);
    did_rst = 0;
    for (int i = 0; i < 4500; i++) begin
      rif.ce_7mp = ($urandom_range(0, 99) < 90);
      rif.ce_7mn = 1'($urandom_range(0, 1));
      if (!did_rst && !m_nint && m_left == INT_LEN - 5) begin
        reset = 1'b1;
        rif.cfg_int_v = 9'd400;
        did_rst = 1;
      end else begin
        reset = 1'b0;
      end
      step();
    end
    reset = 1'b0;
    run(3400, 100);

    // Full 256x256 custom frame, mode change to 48K mid-frame, line interrupt at line 100.
    rif.cfg_htotal = 9'd255; rif.cfg_vtotal = 9'd255;
    rif.cfg_int_v = 9'd3; rif.cfg_int_h = 9'd7;
    rif.line_int_line = 9'd100;
    rif.line_int_en = 1'b1;
    do_reset(2'd3);
    for (int i = 0; i < 65536 + 1200; i++) begin
      vcm = m_pos / (m_H + 1);
      rif.ce_7mp = 1'b1;
      rif.ce_7mn = 1'($urandom_range(0, 1));
      if (m_H == 255 && vcm == 100 && rif.mode == 2'd3) begin
        rif.mode = 2'd1;
        rif.cfg_htotal = 9'($urandom_range(255, 511));
      end
      if (m_H == 255 && vcm == 120) rif.line_int_en = 1'b0;
      if (m_H == 255 && vcm == 150) rif.line_int_line = 9'd1;
      if (m_H == 255 && vcm == 200) rif.line_int_en = 1'b1;
      rif.line_int_ack = (m_H == 255 && m_pos == 100 * 256 - 1) ? 1'b1
                         : ($urandom_range(0, 2999) == 0);
      step();
    end
    rif.line_int_ack = 1'b0;

    @(negedge clk_sys);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
